// File: rtl/galois_divider.sv
// Sequential GF(2^N) divider: q = a * b^(2^N-2) by Fermat inversion, square-and-multiply.
// galois_multiplication is the shared combinational field multiplier (operands up to 2N-1 bits).
module galois_multiplication #(
  parameter int N = 8
) (
  input  logic [2*N-2:0] a_i,
  input  logic [2*N-2:0] b_i,
  input  logic [N:0]     p_i,
  output logic [N-1:0]   y_o
);

  logic [2*N-2:0] t;
  logic [N-1:0]   a_red;
  logic [N-1:0]   r;

  always_comb begin
    t = a_i;
    for (int i = 2*N-2; i >= N; i--) begin
      if (t[i]) t[i -: N+1] = t[i -: N+1] ^ p_i;
    end
    a_red = t[N-1:0];
    // Horner over b: shift-reduce the running product, then add a when the bit is set
    r = '0;
    for (int i = 2*N-2; i >= 0; i--) begin
      r = {r[N-2:0], 1'b0} ^ (r[N-1] ? p_i[N-1:0] : '0) ^ (b_i[i] ? a_red : '0);
    end
    y_o = r;
  end

endmodule

module galois_divider #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N:0]   p,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] q,
  output logic         div_by_zero
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SQUARE,
    S_ITER,
    S_FINAL,
    S_DONE
  } state_t;

  state_t          state_q;
  logic [N-1:0]    a_q, b_q, sq_q, acc_q, quo_q;
  logic [N:0]      p_q;
  logic [CW-1:0]   cnt_q;
  logic            dbz_r_q, dbz_q, busy_q, done_q;

  logic [N-1:0]    mul_x_d, mul_y_d, prod_d;
  logic [N-1:0]    sq_in_d, sq_d;

  // One multiplier serves acc*sq during ITER and acc*a in FINAL; the other squares.
  assign mul_x_d = acc_q;
  assign mul_y_d = (state_q == S_FINAL) ? a_q : sq_q;
  assign sq_in_d = (state_q == S_SQUARE) ? b_q : sq_q;

  galois_multiplication #(.N(N)) u_mul_acc (
    .a_i ({{(N-1){1'b0}}, mul_x_d}),
    .b_i ({{(N-1){1'b0}}, mul_y_d}),
    .p_i (p_q),
    .y_o (prod_d)
  );

  galois_multiplication #(.N(N)) u_mul_sq (
    .a_i ({{(N-1){1'b0}}, sq_in_d}),
    .b_i ({{(N-1){1'b0}}, sq_in_d}),
    .p_i (p_q),
    .y_o (sq_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      sq_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      dbz_r_q <= 1'b0;
      dbz_q   <= 1'b0;
      quo_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            p_q     <= p;
            dbz_r_q <= (b == '0);
            busy_q  <= 1'b1;
            state_q <= S_SQUARE;
          end
        end
        S_SQUARE: begin
          sq_q    <= sq_d;
          acc_q   <= {{(N-1){1'b0}}, 1'b1};
          cnt_q   <= '0;
          state_q <= S_ITER;
        end
        S_ITER: begin
          // acc picks up the old sq; after k steps acc = b^(2^(k+1)-2)
          acc_q <= prod_d;
          sq_q  <= sq_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(N-2)) state_q <= S_FINAL;
        end
        S_FINAL: begin
          quo_q   <= prod_d;
          dbz_q   <= dbz_r_q;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign q           = quo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_galois_divider.sv
// Scoreboard bench for galois_divider: directed vectors, back-to-back spacing,
// input stability, reset cases, and a sweep over every nonzero divisor.
module tb_galois_divider;

  localparam int N   = 8;
  localparam int LAT = N + 1;

  logic         clk, rst, start;
  logic [N-1:0] a_in, b_in;
  logic [N:0]   p_in;
  logic         busy, done, div_by_zero;
  logic [N-1:0] q;

  galois_divider #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a           (a_in),
    .b           (b_in),
    .p           (p_in),
    .busy        (busy),
    .done        (done),
    .q           (q),
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic       dbz;
    int         cyc;
    bit         chk_inv;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_pass = 0;
  int   cyc = 0, n_acc = 0, n_done = 0;
  logic prev_done = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "watchdog timeout");
  end

  // Field arithmetic from the definition: carry-less product then polynomial remainder.
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y, input logic [8:0] pp);
    logic [15:0] prod;
    prod = '0;
    for (int i = 0; i < 8; i++) if (y[i]) prod = prod ^ (16'(x) << i);
    for (int i = 14; i >= 8; i--) if (prod[i]) prod = prod ^ (16'(pp) << (i - 8));
    return prod[7:0];
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] y, input logic [8:0] pp);
    for (int x = 1; x < 256; x++) if (gmul(y, 8'(x), pp) == 8'h01) return 8'(x);
    return 8'h00;
  endfunction

  function automatic logic [7:0] ref_div(input logic [7:0] x, input logic [7:0] y, input logic [8:0] pp);
    if (y == 8'h00) return 8'h00;
    return gmul(x, ginv(y, pp), pp);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      n_done++;
      if (prev_done === 1'b1) check("done_one_cycle", 32'(prev_done), 0);
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(sb.size()), 1);
      end else begin
        e = sb.pop_front();
        check("q", 32'(q), 32'(e.q));
        check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
        check("latency", 32'(cyc - e.cyc), LAT);
        check("busy_at_done", 32'(busy), 1);
        if (e.chk_inv) check("q_times_b", 32'(gmul(q, e.b, 9'h11B)), 32'(e.a));
      end
    end
    prev_done = done;
  end

  // Caller has driven operands and start=1 at posedge+1; the next edge accepts.
  task automatic accept(input logic [7:0] qa, input logic [7:0] qb, input logic [7:0] eq,
                        input logic edz, input bit inv);
    exp_t e;
    @(posedge clk);
    #1;
    e.a = qa; e.b = qb; e.q = eq; e.dbz = edz; e.cyc = cyc; e.chk_inv = inv;
    sb.push_back(e);
    n_acc++;
  endtask

  task automatic b2b(input logic [7:0] va[], input logic [7:0] vb[], input logic [7:0] vq[],
                     input logic vd[], input bit inv);
    for (int i = 0; i < va.size(); i++) begin
      a_in = va[i]; b_in = vb[i]; p_in = 9'h11B; start = 1'b1;
      accept(va[i], vb[i], vq[i], vd[i], inv);
      if (i != va.size() - 1) begin
        repeat (N + 2) @(posedge clk);
        #1;
      end
    end
    start = 1'b0;
    repeat (N + 4) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] ea[], eb[], eq[];
    logic       ed[];
    logic [7:0] ra;

    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; p_in = 9'h11B;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_q", 32'(q), 0);
    check("reset_dbz", 32'(div_by_zero), 0);
    @(posedge clk);
    #1;

    // Single inverse with busy profile through the done cycle
    a_in = 8'h01; b_in = 8'h53; start = 1'b1;
    accept(8'h01, 8'h53, 8'hCA, 1'b0, 1'b0);
    start = 1'b0;
    for (int k = 0; k <= LAT; k++) begin
      @(negedge clk);
      check("busy_during_op", 32'(busy), 1);
      if (k < LAT) check("done_early", 32'(done), 0);
    end
    @(negedge clk);
    check("busy_after_done", 32'(busy), 0);
    repeat (2) @(posedge clk);
    #1;

    ea = '{8'hC1, 8'h53, 8'h57}; eb = '{8'h83, 8'h53, 8'h01};
    eq = '{8'h57, 8'h01, 8'h57}; ed = '{1'b0, 1'b0, 1'b0};
    b2b(ea, eb, eq, ed, 1'b0);

    ea = '{8'h57, 8'h00}; eb = '{8'h00, 8'h53};
    eq = '{8'h00, 8'h00}; ed = '{1'b1, 1'b0};
    b2b(ea, eb, eq, ed, 1'b0);

    // Scramble inputs and pulse start while busy; only the latched operands count
    a_in = 8'hC1; b_in = 8'h83; p_in = 9'h11B; start = 1'b1;
    accept(8'hC1, 8'h83, 8'h57, 1'b0, 1'b0);
    for (int i = 0; i < N + 2; i++) begin
      a_in = 8'($urandom); b_in = 8'($urandom); p_in = 9'($urandom); start = 1'($urandom);
      @(posedge clk);
      #1;
    end
    start = 1'b0; p_in = 9'h11B;
    repeat (3) @(posedge clk);
    #1;

    // Reset while ITER is at cnt=3: no done, outputs cleared
    a_in = 8'h57; b_in = 8'h83; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_q", 32'(q), 0);
    check("midrst_dbz", 32'(div_by_zero), 0);
    repeat (N + 6) @(posedge clk);
    #1;
    a_in = 8'h01; b_in = 8'h53; start = 1'b1;
    accept(8'h01, 8'h53, 8'hCA, 1'b0, 1'b0);
    start = 1'b0;
    repeat (N + 4) @(posedge clk);
    #1;

    // rst and start in the same cycle: start is lost
    rst = 1'b1; start = 1'b1; a_in = 8'h01; b_in = 8'h53;
    @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_start_busy", 32'(busy), 0);
    repeat (N + 6) @(posedge clk);
    #1;

    ea = new[255]; eb = new[255]; eq = new[255]; ed = new[255];
    for (int i = 0; i < 255; i++) begin
      ra = 8'($urandom);
      ea[i] = ra; eb[i] = 8'(i + 1);
      eq[i] = ref_div(ra, 8'(i + 1), 9'h11B);
      ed[i] = 1'b0;
    end
    b2b(ea, eb, eq, ed, 1'b1);

    for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
    check("scoreboard_drained", 32'(sb.size()), 0);
    check("done_count", 32'(n_done), 32'(n_acc));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/galois_divider.md
Name: galois_divider

Overview:
- Sequential GF(2^N) divider: q = a / b = a · b^(2^N−2), computed by Fermat inversion with iterative square-and-multiply.
- Complements the combinational galois_multiplication block; reuses it as its arithmetic core.
- Serves as the inverse/division unit for field arithmetic in the crypto datapaths.
- Start/done handshake, fixed latency, one division in flight.

Parameters:
- N, 8, field degree; operand and result width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  N  dividend polynomial.
- b  input  N  divisor polynomial.
- p  input  N+1  irreducible reduction polynomial, e.g. 0x11B for N=8.
- busy  output  1  high while a division is in progress, including the DONE cycle.
- done  output  1  one-cycle pulse; q and div_by_zero are valid in this cycle and held afterwards.
- q  output  N  quotient a/b.
- div_by_zero  output  1  set when the latched b == 0.

Behaviour:
- Reset:
  - One clock with rst=1 forces state IDLE, busy=0, done=0, q=0, div_by_zero=0, and clears internal registers.
  - Reset overrides everything, including mid-operation; any in-flight division is discarded with no done.
- Arithmetic:
  - All products come from galois_multiplication with operands zero-extended to 2N−1 bits and p passed through.
  - No more than three multiplier instances.
  - a, b and p are latched at start acceptance; later input changes have no effect on the running operation.
- Registers: a_r, b_r, p_r, sq (N), acc (N), cnt (ceil(log2 N) bits), state.
- FSM:
  - IDLE: busy=0. On start=1: latch a, b and p; div_by_zero_r <= (b==0); go to SQUARE.
  - SQUARE: sq <= b_r·b_r; acc <= 1; cnt <= 0; go to ITER.
  - ITER:
    - Each cycle, in parallel: acc <= acc·sq (old sq); sq <= sq·sq; cnt <= cnt+1.
    - After N−1 ITER cycles (cnt == N−2 at the edge), go to FINAL.
    - Invariant: after k iterations, acc = b^(2^(k+1)−2).
  - FINAL: q <= acc·a_r; div_by_zero <= div_by_zero_r; go to DONE.
  - DONE: done=1, busy=1; go to IDLE unconditionally.
- Latency:
  - Start is sampled at edge E. done is high during the cycle following edge E+N+1 (9 cycles for N=8).
  - Latency is fixed and independent of operand values, b==0 included.
  - Earliest next acceptance is at the edge that ends DONE+1, i.e. start held high gives back-to-back divisions every N+3 cycles.
- Boundaries:
  - start while busy (SQUARE, ITER, FINAL, DONE) is ignored and not queued.
  - b == 0: the datapath naturally yields acc=0, so q=0 and div_by_zero=1 at done.
  - a == 0, b ≠ 0: q=0, div_by_zero=0.
  - b == 1: q=a.
  - q and div_by_zero hold their last values until the next FINAL or reset. done is never high for more than one cycle.
  - rst and start asserted together: rst wins and the start is lost.
- All outputs are registered. No combinational path from inputs to outputs.

Test Plan:
- Inverse: N=8, p=0x11B, a=0x01, b=0x53, start one cycle -> done exactly 9 cycles later, q=0xCA, div_by_zero=0, busy high from cycle after start through the done cycle.
- Division and identity:
  - a=0xC1, b=0x83 -> q=0x57.
  - a=0x53, b=0x53 -> q=0x01.
  - a=0x57, b=0x01 -> q=0x57.
  - Each case runs back-to-back with start held high; check the N+3-cycle spacing of done pulses.
- Zero cases:
  - a=0x57, b=0x00 -> q=0x00, div_by_zero=1, same 9-cycle latency.
  - The following division a=0x00, b=0x53 -> q=0x00, div_by_zero=0.
- Input stability: after start, change a, b and p every cycle and pulse start during busy -> result still matches the latched operands; exactly one done per accepted start.
- Reset mid-operation: rst=1 for one cycle during ITER (cnt=3) -> next cycle busy=0, done=0, q=0, div_by_zero=0, no done pulse; a fresh start with a=0x01, b=0x53 then gives q=0xCA.
- Exhaustive self-check: N=8, p=0x11B, all b in 1..255 with a=random -> q·b reduced mod p equals a, using the reference model.
